// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/trap sequencer.
package pipe_ctrl_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StDrain  = 2'd1,
      StCommit = 2'd2
   } state_e;

   // What the pending COMMIT will do
   typedef enum logic [1:0] {
      KindNone = 2'd0,
      KindTrap = 2'd1,
      KindMret = 2'd2
   } kind_e;

   // mcause exception codes
   localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

   // Cause with ilegl > ebreak > ecall precedence; mret (or nothing) encodes as 0.
   function automatic logic [3:0] enc_cause(input logic ilegl, input logic ebreak,
                                            input logic ecall);
      logic [3:0] c;
      c = 4'd0;
      if (ilegl)       c = CAUSE_ILLEGAL;
      else if (ebreak) c = CAUSE_BREAKPOINT;
      else if (ecall)  c = CAUSE_ECALL_M;
      return c;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Event inputs and stall/flush/redirect/commit outputs of the pipeline sequencer.
interface pipe_ctrl_if #(
   parameter int unsigned XLEN = 64
) ();
   logic            id_load_use_i;
   logic            ex_branch_taken_i;
   logic [XLEN-1:0] ex_branch_target_i;
   logic [XLEN-1:0] ex_pc_i;
   logic            ex_ilegl_i;
   logic            ex_ebreak_i;
   logic            ex_ecall_i;
   logic            ex_mret_i;
   logic            mem_stall_i;
   logic [XLEN-1:0] csr_mtvec_i;
   logic [XLEN-1:0] csr_mepc_i;

   logic            pc_stall_o;
   logic            if_id_stall_o;
   logic            id_ex_stall_o;
   logic            ex_mem_stall_o;
   logic            if_id_flush_o;
   logic            id_ex_flush_o;
   logic            ex_mem_flush_o;
   logic            mem_wb_flush_o;
   logic            id_flush_o;
   logic            redirect_valid_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            trap_o;
   logic [3:0]      trap_cause_o;
   logic [XLEN-1:0] trap_epc_o;
   logic            mret_o;

   // Pipeline side: raises events, consumes controls
   modport master (
      output id_load_use_i, ex_branch_taken_i, ex_branch_target_i, ex_pc_i,
             ex_ilegl_i, ex_ebreak_i, ex_ecall_i, ex_mret_i, mem_stall_i,
             csr_mtvec_i, csr_mepc_i,
      input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o, id_flush_o,
             redirect_valid_o, redirect_pc_o, trap_o, trap_cause_o, trap_epc_o, mret_o
   );

   // Sequencer side
   modport slave (
      input  id_load_use_i, ex_branch_taken_i, ex_branch_target_i, ex_pc_i,
             ex_ilegl_i, ex_ebreak_i, ex_ecall_i, ex_mret_i, mem_stall_i,
             csr_mtvec_i, csr_mepc_i,
      output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o, id_flush_o,
             redirect_valid_o, redirect_pc_o, trap_o, trap_cause_o, trap_epc_o, mret_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and trap sequencer: per-stage stall/flush, PC redirect, trap/mret commit.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned DRAIN_CYCLES = 2   // legal 1..15
) (
   input logic          clk_i,
   input logic          rst_n_i,
   pipe_ctrl_if.slave   bus
);

   localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES);

   state_e          r_state, w_state_next;
   kind_e           r_kind, w_kind_next;
   logic [3:0]      r_cnt, w_cnt_next;
   logic [3:0]      r_cause, w_cause_next;
   logic [XLEN-1:0] r_epc, w_epc_next;
   logic            w_exc;

   assign w_exc = bus.ex_ilegl_i | bus.ex_ebreak_i | bus.ex_ecall_i | bus.ex_mret_i;

   // State register plus drain counter and latched trap details
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= StRun;
         r_kind  <= KindNone;
         r_cnt   <= 4'd0;
         r_cause <= 4'd0;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_next;
         r_kind  <= w_kind_next;
         r_cnt   <= w_cnt_next;
         r_cause <= w_cause_next;
         r_epc   <= w_epc_next;
      end
   end

   // Next-state: capture exception in RUN, count non-stalled drain cycles, clear after commit
   always_comb begin
      w_state_next = r_state;
      w_kind_next  = r_kind;
      w_cnt_next   = r_cnt;
      w_cause_next = r_cause;
      w_epc_next   = r_epc;
      unique case (r_state)
         StRun: begin
            if (!bus.mem_stall_i && w_exc) begin
               w_kind_next  = (bus.ex_ilegl_i | bus.ex_ebreak_i | bus.ex_ecall_i) ?
                              KindTrap : KindMret;
               w_cause_next = enc_cause(bus.ex_ilegl_i, bus.ex_ebreak_i, bus.ex_ecall_i);
               w_epc_next   = bus.ex_pc_i;
               w_cnt_next   = DrainInit;
               w_state_next = StDrain;
            end
         end
         StDrain: begin
            if (!bus.mem_stall_i) begin
               w_cnt_next = r_cnt - 4'd1;
               if (r_cnt == 4'd1) w_state_next = StCommit;
            end
         end
         StCommit: begin
            // Latches are cleared so trap_* read 0 again in RUN
            w_state_next = StRun;
            w_kind_next  = KindNone;
            w_cnt_next   = 4'd0;
            w_cause_next = 4'd0;
            w_epc_next   = '0;
         end
         default: w_state_next = StRun;
      endcase
   end

   // Outputs: stall/flush/redirect decode from state and current events
   always_comb begin
      bus.pc_stall_o       = 1'b0;
      bus.if_id_stall_o    = 1'b0;
      bus.id_ex_stall_o    = 1'b0;
      bus.ex_mem_stall_o   = 1'b0;
      bus.if_id_flush_o    = 1'b0;
      bus.id_ex_flush_o    = 1'b0;
      bus.ex_mem_flush_o   = 1'b0;
      bus.mem_wb_flush_o   = 1'b0;
      bus.id_flush_o       = 1'b0;
      bus.redirect_valid_o = 1'b0;
      bus.redirect_pc_o    = '0;
      unique case (r_state)
         StRun: begin
            if (bus.mem_stall_i) begin
               bus.pc_stall_o     = 1'b1;
               bus.if_id_stall_o  = 1'b1;
               bus.id_ex_stall_o  = 1'b1;
               bus.ex_mem_stall_o = 1'b1;
               bus.mem_wb_flush_o = 1'b1;
            end else if (w_exc) begin
               bus.pc_stall_o     = 1'b1;
               bus.if_id_flush_o  = 1'b1;
               bus.id_ex_flush_o  = 1'b1;
               bus.ex_mem_flush_o = 1'b1;
               bus.id_flush_o     = 1'b1;
            end else if (bus.ex_branch_taken_i) begin
               bus.redirect_valid_o = 1'b1;
               bus.redirect_pc_o    = bus.ex_branch_target_i;
               bus.if_id_flush_o    = 1'b1;
               bus.id_ex_flush_o    = 1'b1;
               bus.id_flush_o       = 1'b1;
            end else if (bus.id_load_use_i) begin
               bus.pc_stall_o    = 1'b1;
               bus.if_id_stall_o = 1'b1;
               bus.id_ex_flush_o = 1'b1;
            end
         end
         StDrain: begin
            bus.pc_stall_o = 1'b1;
            if (bus.mem_stall_i) begin
               // Stalled registers hold rather than flush
               bus.if_id_stall_o  = 1'b1;
               bus.id_ex_stall_o  = 1'b1;
               bus.ex_mem_stall_o = 1'b1;
               bus.mem_wb_flush_o = 1'b1;
            end else begin
               bus.if_id_flush_o  = 1'b1;
               bus.id_ex_flush_o  = 1'b1;
               bus.ex_mem_flush_o = 1'b1;
            end
         end
         StCommit: begin
            bus.redirect_valid_o = 1'b1;
            bus.redirect_pc_o    = (r_kind == KindMret) ? bus.csr_mepc_i : bus.csr_mtvec_i;
            bus.if_id_flush_o    = 1'b1;
            bus.id_ex_flush_o    = 1'b1;
         end
         default: ;
      endcase
   end

   // Commit pulses come straight from registered state
   assign bus.trap_o       = (r_state == StCommit) && (r_kind == KindTrap);
   assign bus.mret_o       = (r_state == StCommit) && (r_kind == KindMret);
   assign bus.trap_cause_o = r_cause;
   assign bus.trap_epc_o   = r_epc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations, monitor checks them.
module tb_pipe_ctrl;

   localparam logic [11:0] PC_S    = 12'h800;
   localparam logic [11:0] IFID_S  = 12'h400;
   localparam logic [11:0] IDEX_S  = 12'h200;
   localparam logic [11:0] EXMEM_S = 12'h100;
   localparam logic [11:0] IFID_F  = 12'h080;
   localparam logic [11:0] IDEX_F  = 12'h040;
   localparam logic [11:0] EXMEM_F = 12'h020;
   localparam logic [11:0] MEMWB_F = 12'h010;
   localparam logic [11:0] ID_F    = 12'h008;
   localparam logic [11:0] RDV     = 12'h004;
   localparam logic [11:0] TRAP    = 12'h002;
   localparam logic [11:0] MRET    = 12'h001;

   localparam logic [11:0] TAKE = PC_S | IFID_F | IDEX_F | EXMEM_F | ID_F;
   localparam logic [11:0] DRN  = PC_S | IFID_F | IDEX_F | EXMEM_F;
   localparam logic [11:0] MST  = PC_S | IFID_S | IDEX_S | EXMEM_S | MEMWB_F;

   typedef struct packed {
      logic [11:0] ctl;
      logic [63:0] rpc;
      logic [3:0]  cause;
      logic [63:0] epc;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   exp_t  q[$];
   string nq[$];
   int    n_checks = 0;
   int    n_pass = 0;

   pipe_ctrl_if #(.XLEN(64)) bus ();

   pipe_ctrl #(.XLEN(64), .DRAIN_CYCLES(2)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Push one cycle's expectation, then move to just after the next rising edge
   task automatic cyc(input string nm, input logic [11:0] ctl, input logic [63:0] rpc,
                      input logic [3:0] cause, input logic [63:0] epc);
      exp_t e;
      e.ctl = ctl; e.rpc = rpc; e.cause = cause; e.epc = epc;
      q.push_back(e);
      nq.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.id_load_use_i     = 1'b0;
      bus.ex_branch_taken_i = 1'b0;
      bus.ex_branch_target_i = 64'h0;
      bus.ex_ilegl_i        = 1'b0;
      bus.ex_ebreak_i       = 1'b0;
      bus.ex_ecall_i        = 1'b0;
      bus.ex_mret_i         = 1'b0;
      bus.mem_stall_i       = 1'b0;
   endtask

   // Full trap/mret sequence with DRAIN_CYCLES=2; stalls land between the two drain cycles
   task automatic do_exc(input string nm, input logic [3:0] flags, input logic [63:0] pc,
                         input logic [3:0] cause, input logic is_mret,
                         input logic [63:0] rpc, input int stalls);
      {bus.ex_ilegl_i, bus.ex_ebreak_i, bus.ex_ecall_i, bus.ex_mret_i} = flags;
      bus.ex_pc_i = pc;
      cyc({nm, "_take"}, TAKE, 64'h0, 4'd0, 64'h0);
      clear_in();
      bus.ex_ilegl_i = 1'b1;  // must be ignored while draining
      cyc({nm, "_drain1"}, DRN, 64'h0, cause, pc);
      clear_in();
      for (int i = 0; i < stalls; i++) begin
         bus.mem_stall_i = 1'b1;
         cyc({nm, "_dstall"}, MST, 64'h0, cause, pc);
      end
      clear_in();
      cyc({nm, "_drain2"}, DRN, 64'h0, cause, pc);
      cyc({nm, "_commit"}, (is_mret ? MRET : TRAP) | RDV | IFID_F | IDEX_F, rpc, cause, pc);
      cyc({nm, "_idle"}, 12'h0, 64'h0, 4'd0, 64'h0);
   endtask

   // Monitor: every falling edge, compare DUT outputs with the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = q.pop_front();
            nm = nq.pop_front();
            a.ctl = {bus.pc_stall_o, bus.if_id_stall_o, bus.id_ex_stall_o, bus.ex_mem_stall_o,
                     bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_mem_flush_o,
                     bus.mem_wb_flush_o, bus.id_flush_o, bus.redirect_valid_o,
                     bus.trap_o, bus.mret_o};
            a.rpc   = bus.redirect_pc_o;
            a.cause = bus.trap_cause_o;
            a.epc   = bus.trap_epc_o;
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got ctl=%03h rpc=%h cause=%0d epc=%h, want ctl=%03h rpc=%h cause=%0d epc=%h",
                          nm, a.ctl, a.rpc, a.cause, a.epc, e.ctl, e.rpc, e.cause, e.epc);
         end
      end
   end

   initial begin
      clear_in();
      bus.ex_pc_i     = 64'h0;
      bus.csr_mtvec_i = 64'h0;
      bus.csr_mepc_i  = 64'h0;
      @(posedge clk);
      #1;
      cyc("reset0", 12'h0, 64'h0, 4'd0, 64'h0);
      cyc("reset1", 12'h0, 64'h0, 4'd0, 64'h0);
      rst_n = 1'b1;
      cyc("idle", 12'h0, 64'h0, 4'd0, 64'h0);

      // Load-use: one bubble only
      bus.id_load_use_i = 1'b1;
      cyc("load_use", PC_S | IFID_S | IDEX_F, 64'h0, 4'd0, 64'h0);
      clear_in();
      cyc("load_use_after", 12'h0, 64'h0, 4'd0, 64'h0);

      // Branch beats load-use
      bus.ex_branch_taken_i  = 1'b1;
      bus.ex_branch_target_i = 64'h8000_0100;
      bus.id_load_use_i      = 1'b1;
      cyc("branch", RDV | IFID_F | IDEX_F | ID_F, 64'h8000_0100, 4'd0, 64'h0);
      clear_in();

      // mem stall beats a coincident ecall; ecall is re-evaluated next cycle
      bus.csr_mtvec_i = 64'h8000_1000;
      bus.csr_mepc_i  = 64'h8000_0044;
      bus.mem_stall_i = 1'b1;
      bus.ex_ecall_i  = 1'b1;
      bus.ex_pc_i     = 64'h8000_0040;
      cyc("mstall_run", MST, 64'h0, 4'd0, 64'h0);
      clear_in();

      // ecall with a coincident branch: exception wins, no redirect
      bus.ex_branch_taken_i  = 1'b1;
      bus.ex_branch_target_i = 64'h8000_0200;
      do_exc("ecall", 4'b0010, 64'h8000_0040, 4'd11, 1'b0, 64'h8000_1000, 0);

      // Same ecall, 3 stalled drain cycles delay commit by exactly 3
      do_exc("ecall_st", 4'b0010, 64'h8000_0040, 4'd11, 1'b0, 64'h8000_1000, 3);

      // mret
      do_exc("mret", 4'b0001, 64'h8000_0050, 4'd0, 1'b1, 64'h8000_0044, 0);

      // All four flags: illegal instruction takes precedence
      do_exc("prec", 4'b1111, 64'h8000_0060, 4'd2, 1'b0, 64'h8000_1000, 0);

      // Reset in the middle of DRAIN: outputs clear immediately, no trap later
      bus.ex_ebreak_i = 1'b1;
      bus.ex_pc_i     = 64'h8000_0070;
      cyc("rd_take", TAKE, 64'h0, 4'd0, 64'h0);
      clear_in();
      cyc("rd_drain1", DRN, 64'h0, 4'd3, 64'h8000_0070);
      rst_n = 1'b0;
      cyc("rd_reset", 12'h0, 64'h0, 4'd0, 64'h0);
      cyc("rd_reset_hold", 12'h0, 64'h0, 4'd0, 64'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc("rd_no_trap", 12'h0, 64'h0, 4'd0, 64'h0);
      do_exc("ebreak", 4'b0100, 64'h8000_0080, 4'd3, 1'b0, 64'h8000_1000, 0);

      // Let the monitor drain the queue, bounded
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_queue: got %0d pending, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and trap sequencer for the 5-stage RV64I pipeline (IF/ID/EX/MEM/WB).
- Combines four event sources into per-stage stall/flush controls and a single PC redirect: decoder load-use, EX branch/jump resolution, EX exception/mret flags, and MEM data-access wait.
- Sequences trap entry and mret: drains older instructions, then pulses a one-cycle commit to the CSR unit and redirects fetch.

Parameters:
- XLEN, 64, datapath/PC width.
- DRAIN_CYCLES, 2, non-stalled cycles to wait for older instructions to leave MEM and WB before trap commit; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- id_load_use_i  in  1  load-use hazard from decoder
- ex_branch_taken_i  in  1  EX resolved taken branch/jal/jalr
- ex_branch_target_i  in  XLEN  redirect target
- ex_pc_i  in  XLEN  PC of EX instruction
- ex_ilegl_i / ex_ebreak_i / ex_ecall_i / ex_mret_i  in  1 each  EX exception/return flags
- mem_stall_i  in  1  MEM data access not ready
- csr_mtvec_i  in  XLEN  trap vector
- csr_mepc_i  in  XLEN  return address
- pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out  1 each  hold register
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  load bubble
- id_flush_o  out  1  ID instruction being killed; feeds decoder id_flush_i
- redirect_valid_o  out  1  load PC from redirect_pc_o
- redirect_pc_o  out  XLEN
- trap_o  out  1  one-cycle CSR commit: mepc<=trap_epc_o, mcause<=trap_cause_o
- trap_cause_o  out  4
- trap_epc_o  out  XLEN
- mret_o  out  1  one-cycle CSR mstatus restore

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous and active-low.
- Reset state: RUN, drain counter 0, latched cause/epc/kind cleared.
- trap_o, mret_o and trap_* are registered and read 0 during reset.
- All other outputs are combinational from inputs and state; with all inputs 0 in RUN, every output is 0.
- FSM states:
  - RUN: normal operation.
  - DRAIN: waiting for older instructions to retire.
  - COMMIT: one cycle, then back to RUN.
- Priority in RUN (highest first):
  1. mem_stall_i: stall PC, IF/ID, ID/EX, EX/MEM; flush MEM/WB. All EX and ID events are ignored this cycle and re-evaluated next cycle.
  2. Exception/mret (any of the four flags):
     - Latch kind; latch cause: ilegl=2, ebreak=3, ecall=11, mret=0. If several flags are set, the precedence is ilegl>ebreak>ecall>mret.
     - Latch epc=ex_pc_i.
     - Flush IF/ID, ID/EX, EX/MEM; assert id_flush_o; stall PC.
     - Load counter with DRAIN_CYCLES and go to DRAIN.
  3. ex_branch_taken_i: redirect_valid_o=1, redirect_pc_o=ex_branch_target_i; flush IF/ID and ID/EX; assert id_flush_o. A coincident load-use is ignored.
  4. id_load_use_i: stall PC and IF/ID; flush ID/EX. Exactly one bubble per assertion.
- DRAIN:
  - Stall PC; flush IF/ID, ID/EX, EX/MEM every cycle.
  - Counter decrements only when mem_stall_i=0. When mem_stall_i=1, also apply the mem-stall controls and hold the counter.
  - New EX flags are ignored.
  - Go to COMMIT when the counter reaches 0 in a non-stalled cycle, i.e. after DRAIN_CYCLES non-stalled DRAIN cycles.
- COMMIT (exactly 1 cycle):
  - Trap: trap_o=1 and redirect to csr_mtvec_i.
  - mret: mret_o=1 and redirect to csr_mepc_i.
  - redirect_valid_o=1; flush IF/ID and ID/EX; then go to RUN.
  - csr_mtvec_i and csr_mepc_i are sampled in this cycle, so an older CSR write has already landed.
- Stall and flush of the same register are never both asserted, except that a stalled register is not flushed.
- Reset asserted in DRAIN or COMMIT: immediate return to RUN; the pending trap is discarded with no trap_o pulse.
- A branch flag coincident with an exception flag: the exception wins and there is no branch redirect.

Decomposition:
- Shared defines file gets:
  - FSM state encodings (RUN/DRAIN/COMMIT, 2 bits).
  - mcause codes CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11.
  - The latched-kind encoding.
- No sub-module required. The drain counter and cause encoder stay inline.

Test Plan:
- Load-use: id_load_use_i=1 for one cycle in RUN -> pc_stall_o=if_id_stall_o=id_ex_flush_o=1 that cycle only, no redirect.
- Branch vs load-use: ex_branch_taken_i=1, target=0x8000_0100, id_load_use_i=1 -> redirect_valid_o=1, redirect_pc_o=0x8000_0100, if_id_flush_o=id_ex_flush_o=id_flush_o=1, pc_stall_o=0.
- ecall: ex_ecall_i=1, ex_pc_i=0x8000_0040, mtvec=0x8000_1000, DRAIN_CYCLES=2 -> DRAIN for 2 cycles, then trap_o=1, trap_cause_o=11, trap_epc_o=0x8000_0040, redirect_pc_o=0x8000_1000 for one cycle.
- mem stall during drain: same as the ecall case with mem_stall_i=1 for 3 cycles in DRAIN -> commit delayed exactly 3 cycles; mem_wb_flush_o=1 during the stall.
- mret: ex_mret_i=1, mepc=0x8000_0044 -> after drain, mret_o=1, trap_o=0, redirect_pc_o=0x8000_0044.
- Reset mid-DRAIN: assert rst_n_i=0 in DRAIN -> all outputs 0 asynchronously; no trap_o after release; next ebreak gives cause 3 normally.
